// File: rtl/regfile_write_arbiter_if.sv
// regfile_write_arbiter_if: writeback request/response bundle between the two sources, the arbiter and the register file
//   slave  (arbiter) : hold, alu_valid/addr/data, mem_valid/addr/data in; alu_ready, mem_ready, wr_enable/addr/data, last_grant out
//   master (sources) : the mirror image of slave
interface regfile_write_arbiter_if #(parameter int DATA_W = 32, parameter int ADDR_W = 5);
  logic              hold;
  logic              alu_valid;
  logic [ADDR_W-1:0] alu_addr;
  logic [DATA_W-1:0] alu_data;
  logic              alu_ready;
  logic              mem_valid;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;
  logic              mem_ready;
  logic              wr_enable;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              last_grant;
  modport slave (
    input  hold, alu_valid, alu_addr, alu_data, mem_valid, mem_addr, mem_data,
    output alu_ready, mem_ready, wr_enable, wr_addr, wr_data, last_grant
  );
  modport master (
    output hold, alu_valid, alu_addr, alu_data, mem_valid, mem_addr, mem_data,
    input  alu_ready, mem_ready, wr_enable, wr_addr, wr_data, last_grant
  );
endinterface

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: round-robin share of the register-file write port between ALU and load writeback
//   clk   : rising-edge clock
//   reset : synchronous active-high reset
//   bus   : regfile_write_arbiter_if.slave (requests in, readies + registered write port out)
//   REGWR_ZERO_DROP_EN : when defined, granted writes to register 31 (XZR) never raise wr_enable
module regfile_write_arbiter (
  input logic                       clk,
  input logic                       reset,
  regfile_write_arbiter_if.slave    bus
);
  logic alu_gnt, mem_gnt, wr_en_next;
  // last_grant=1 means MEM won last, so ALU takes a contested cycle
  always_comb begin
    bus.alu_ready = !reset && !bus.hold && bus.alu_valid && (!bus.mem_valid || bus.last_grant);
    bus.mem_ready = !reset && !bus.hold && bus.mem_valid && (!bus.alu_valid || !bus.last_grant);
    alu_gnt = bus.alu_valid && bus.alu_ready;
    mem_gnt = bus.mem_valid && bus.mem_ready;
`ifdef REGWR_ZERO_DROP_EN
    wr_en_next = alu_gnt ? !(&bus.alu_addr) : mem_gnt ? !(&bus.mem_addr) : 1'b0;
`else
    wr_en_next = alu_gnt || mem_gnt;
`endif
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.wr_enable  <= 1'b0;
      bus.wr_addr    <= '0;
      bus.wr_data    <= '0;
      bus.last_grant <= 1'b1;
    end else begin
      bus.wr_enable <= wr_en_next;
      if (alu_gnt) begin
        bus.wr_addr    <= bus.alu_addr;
        bus.wr_data    <= bus.alu_data;
        bus.last_grant <= 1'b0;
      end else if (mem_gnt) begin
        bus.wr_addr    <= bus.mem_addr;
        bus.wr_data    <= bus.mem_data;
        bus.last_grant <= 1'b1;
      end
    end
  end
endmodule
